fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_add4.sv | 7 +
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage.
// Holds the fetch FSM encoding and the IF/ID payload layout.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
  } if_id_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// Single-cycle ack strobe qualified by imem_req.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_add4.sv
// Sequential pc incrementer, wraps modulo 2^32.
module fetch_unit_add4 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = a + 32'd4;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, one-entry
// hold buffer for ID back-pressure, drop of in-flight data on redirect.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic [31:0]        if_inst
);

  localparam if_id_t OUT_RST = '{
    pc:       32'h0,
    pc_plus4: 32'h0,
    inst:     INST_NOP
  };

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  if_id_t       out_q, out_d;
  if_id_t       hb_q, hb_d;
  logic         valid_q, valid_d;

  logic [31:0]  pc_plus4;
  logic         req;
  logic         ack_v;
  logic         slot_free;
  if_id_t       fetched;

  fetch_unit_add4 u_add4 (
    .a (pc_q),
    .y (pc_plus4)
  );

  assign req       = (state_q == FS_WAIT) || (state_q == FS_DROP);
  assign ack_v     = req && imem.imem_ack;
  assign slot_free = !valid_q || !stall;

  assign fetched = '{
    pc:       pc_q,
    pc_plus4: pc_plus4,
    inst:     imem.imem_rdata
  };

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    out_d   = out_q;
    hb_d    = hb_q;
    valid_d = valid_q;
    if (redirect) begin
      valid_d = 1'b0;
      // An unanswered request must be drained before the new pc goes out
      if (req && !ack_v) begin
        state_d = FS_DROP;
        tgt_d   = align_pc(redirect_pc);
      end else begin
        state_d = FS_WAIT;
        pc_d    = align_pc(redirect_pc);
      end
    end else begin
      if (!stall) valid_d = 1'b0;
      unique case (state_q)
        FS_IDLE: state_d = FS_WAIT;
        FS_WAIT: begin
          if (ack_v) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              out_d   = fetched;
              valid_d = 1'b1;
            end else begin
              hb_d    = fetched;
              state_d = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            out_d   = hb_q;
            valid_d = 1'b1;
            state_d = FS_WAIT;
          end
        end
        FS_DROP: begin
          if (ack_v) begin
            pc_d    = tgt_q;
            state_d = FS_WAIT;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      out_q   <= OUT_RST;
      hb_q    <= OUT_RST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      out_q   <= out_d;
      hb_q    <= hb_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign if_valid    = valid_q;
  assign if_pc       = out_q.pc;
  assign if_pc_plus4 = out_q.pc_plus4;
  assign if_inst     = out_q.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model
// compared every cycle, plus literal spot checks.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc, if_pc_plus4, if_inst;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .if_inst     (if_inst)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: outstanding address, optional pending redirect,
  // a FIFO of fetched-but-unaccepted words, and the visible output slot.
  logic        m_alive = 1'b0;
  logic [31:0] m_addr  = RST_PC;
  logic        m_drop  = 1'b0;
  logic [31:0] m_tgt   = 32'h0;
  logic        m_v     = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic [31:0] m_inst  = 32'h13;
  logic [95:0] m_q[$];

  always @(posedge clk or posedge rst) begin
    logic        r, a;
    logic [31:0] t;
    logic [95:0] rec;
    if (rst) begin
      m_alive = 1'b0;
      m_addr  = RST_PC;
      m_drop  = 1'b0;
      m_tgt   = 32'h0;
      m_v     = 1'b0;
      m_pc    = 32'h0;
      m_pc4   = 32'h0;
      m_inst  = 32'h13;
      m_q.delete();
    end else begin
      r = m_alive && (m_q.size() == 0);
      a = r && bus.imem_ack;
      if (redirect) begin
        t = {redirect_pc[31:2], 2'b00};
        m_v = 1'b0;
        m_q.delete();
        if (r && !a) begin
          m_drop = 1'b1;
          m_tgt  = t;
        end else begin
          m_drop = 1'b0;
          m_addr = t;
        end
        m_alive = 1'b1;
      end else begin
        if (!stall) m_v = 1'b0;
        if (!m_alive) begin
          m_alive = 1'b1;
        end else if (m_drop) begin
          if (a) begin
            m_addr = m_tgt;
            m_drop = 1'b0;
          end
        end else if (m_q.size() != 0) begin
          if (!stall) begin
            {m_pc, m_pc4, m_inst} = m_q.pop_front();
            m_v = 1'b1;
          end
        end else if (a) begin
          rec = {m_addr, m_addr + 32'd4, bus.imem_rdata};
          m_addr = m_addr + 32'd4;
          if (!m_v) begin
            {m_pc, m_pc4, m_inst} = rec;
            m_v = 1'b1;
          end else begin
            m_q.push_back(rec);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'b0, if_valid}, {31'b0, m_v});
    chk("m_pc", if_pc, m_pc);
    chk("m_pc4", if_pc_plus4, m_pc4);
    chk("m_inst", if_inst, m_inst);
    chk("m_req", {31'b0, bus.imem_req},
        {31'b0, m_alive && (m_q.size() == 0)});
    chk("m_addr", bus.imem_addr, m_addr);
  end

  task automatic step(input logic s, input logic r,
                      input logic [31:0] rp, input logic a,
                      input logic [31:0] d);
    stall          = s;
    redirect       = r;
    redirect_pc    = rp;
    bus.imem_ack   = a;
    bus.imem_rdata = d;
    @(negedge clk);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tag, "_pc"}, if_pc, 32'h0);
    chk({tag, "_pc4"}, if_pc_plus4, 32'h0);
    chk({tag, "_inst"}, if_inst, 32'h0000_0013);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'h0);
    chk({tag, "_addr"}, bus.imem_addr, RST_PC);
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hBAD0_0000);
    chk_rst_vals("rst");
    rst = 1'b0;
    // Stray ack while IDLE must be ignored
    step(0, 0, 0, 1, 32'hBAD0_0001);
    chk("idle_valid", {31'b0, if_valid}, 32'h0);
    chk("idle_req", {31'b0, bus.imem_req}, 32'h1);
    chk("idle_addr", bus.imem_addr, 32'h0);

    // Back-to-back fetch
    step(0, 0, 0, 1, 32'h00A0_0093);
    chk("b2b0_pc", if_pc, 32'h0);
    chk("b2b0_inst", if_inst, 32'h00A0_0093);
    step(0, 0, 0, 1, 32'h0010_0113);
    chk("b2b1_pc", if_pc, 32'h4);
    step(0, 0, 0, 1, 32'h0020_0193);
    chk("b2b2_pc", if_pc, 32'h8);
    chk("b2b2_pc4", if_pc_plus4, 32'hC);
    chk("b2b2_valid", {31'b0, if_valid}, 32'h1);

    // Back-pressure into the hold buffer
    step(1, 0, 0, 1, 32'hAAAA_0001);
    chk("hold_pc", if_pc, 32'h8);
    chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hBAD0_0002);
    chk("hold3_inst", if_inst, 32'h0020_0193);
    step(0, 0, 0, 0, 0);
    chk("rel_pc", if_pc, 32'hC);
    chk("rel_inst", if_inst, 32'hAAAA_0001);
    chk("rel_addr", bus.imem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    chk("drain_valid", {31'b0, if_valid}, 32'h0);

    // Redirect with ack two cycles later
    step(0, 1, 32'h0000_0103, 0, 0);
    chk("drop_addr", bus.imem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("drop_valid", {31'b0, if_valid}, 32'h0);
    chk("drop_next", bus.imem_addr, 32'h100);
    step(0, 0, 0, 1, 32'h0001_3579);
    chk("tgt_pc", if_pc, 32'h100);
    chk("tgt_inst", if_inst, 32'h0001_3579);

    // Redirect with same-cycle ack while stalled
    step(1, 1, 32'h0000_0200, 1, 32'hBAD0_0003);
    chk("rac_valid", {31'b0, if_valid}, 32'h0);
    chk("rac_addr", bus.imem_addr, 32'h200);
    chk("rac_req", {31'b0, bus.imem_req}, 32'h1);

    // Re-redirect while dropping
    step(0, 1, 32'h0000_0040, 0, 0);
    step(0, 1, 32'h0000_0080, 0, 0);
    chk("redrop_addr", bus.imem_addr, 32'h200);
    step(0, 0, 0, 1, 32'hBAD0_0004);
    chk("redrop_next", bus.imem_addr, 32'h80);

    // pc wrap
    step(0, 1, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 0, 1, 32'hBAD0_0005);
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'h0041_8193);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_next", bus.imem_addr, 32'h0);

    // Asynchronous reset while dropping
    step(0, 0, 0, 1, 32'h1111_0001);
    step(0, 0, 0, 1, 32'h1111_0002);
    step(0, 1, 32'h0000_0300, 0, 0);
    chk("pre_rst_addr", bus.imem_addr, 32'h8);
    #2 rst = 1'b1;
    #1 chk_rst_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, 32'hBAD0_0006);
    chk("post_req", {31'b0, bus.imem_req}, 32'h1);
    chk("post_addr", bus.imem_addr, RST_PC);
    step(0, 0, 0, 1, 32'h2222_0001);
    chk("post_pc", if_pc, RST_PC);
    chk("post_inst", if_inst, 32'h2222_0001);
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
